// File: rtl/mix_columns_iter.sv
// AES forward MixColumns, one 32-bit column per clock through a single column multiplier.
// Holds one 128-bit state; a bypass flag returns the state unchanged for the final round.
module mix_columns_iter #(
    parameter int NCOL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_col;
    logic [127:0]   r_data;
    logic [127:0]   w_data_calc;
    logic [31:0]    w_cols [NCOL];
    logic [31:0]    w_col_in;
    logic [31:0]    w_col_out;
    logic           w_last_col;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Split the state into columns and splice the freshly mixed column back at r_col.
    for (genvar gi = 0; gi < NCOL; gi++) begin : g_cols
        assign w_cols[gi] = r_data[127-32*gi -: 32];
        assign w_data_calc[127-32*gi -: 32] =
            (r_col == 2'(gi)) ? w_col_out : w_cols[gi];
    end

    assign w_col_in   = w_cols[r_col];
    assign w_last_col = (r_col == 2'(NCOL - 1));

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        a0 = w_col_in[31:24];
        a1 = w_col_in[23:16];
        a2 = w_col_in[15:8];
        a3 = w_col_in[7:0];
        w_col_out = {
            xtime(a0) ^ mul3(a1)  ^ a2        ^ a3,
            a0        ^ xtime(a1) ^ mul3(a2)  ^ a3,
            a0        ^ a1        ^ xtime(a2) ^ mul3(a3),
            mul3(a0)  ^ a1        ^ a2        ^ xtime(a3)
        };
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = in_bypass ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last_col) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= 2'd0;
            r_data  <= 128'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_col  <= 2'd0;
                    end
                end
                S_CALC: begin
                    r_data <= w_data_calc;
                    r_col  <= r_col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_data = r_data;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mix_columns_iter.sv
// Randomised and directed bench for mix_columns_iter against a matrix-multiply GF(2^8) model.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = 128'd0;
    logic         in_bypass = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int           acc_q [$];
    logic [127:0] exp_q [$];
    logic [127:0] got_q [$];

    localparam logic [127:0] APPB_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] APPB_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    mix_columns_iter #(.NCOL(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Generic GF(2^8) multiply by shift-and-add, independent of any fixed coefficient.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (byp) return s;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'd0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef[(k - row + 4) % 4], s[127 - 8*(4*c + k) -: 8]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            acc_q.push_back(cyc);
            exp_q.push_back(mix_ref(in_data, in_bypass));
        end
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One transaction; lat = edges from input accept to output accept.
    task automatic do_txn(input string tag, input logic [127:0] d, input logic byp,
                          input int hold, output logic [127:0] res, output int lat);
        int n;
        in_data = d; in_bypass = byp; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        check({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0; in_data = rand128(); in_bypass = $urandom_range(0, 1);
        out_ready = (hold == 0);
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        check({tag, "_out_valid"}, {127'd0, out_valid}, 128'd1);
        for (int i = 0; i < hold; i++) tick();
        check({tag, "_in_ready_done"}, {127'd0, in_ready}, 128'd0);
        out_ready = 1'b1;
        res = out_data;
        tick();
        lat = lat + hold + 1;
        check({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        logic [127:0] res, d, bp_other;
        int lat, n;

        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        do_txn("appb", APPB_IN, 1'b0, 0, res, lat);
        check("appb_data", res, APPB_OUT);
        check("appb_lat", 128'(lat), 128'd5);
        $display("txn appb    out=%h lat=%0d", res, lat);

        d = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        do_txn("colid", d, 1'b0, 0, res, lat);
        check("colid_data", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        $display("txn colid   out=%h lat=%0d", res, lat);

        d = 128'h00112233_44556677_8899aabb_ccddeeff;
        do_txn("bypass", d, 1'b1, 0, res, lat);
        check("bypass_data", res, d);
        check("bypass_lat", 128'(lat), 128'd1);
        $display("txn bypass  out=%h lat=%0d", res, lat);

        // Backpressure with competing input traffic.
        acc_q.delete();
        in_data = APPB_IN; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        bp_other = rand128();
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_data = bp_other; in_bypass = 1'b0;
            tick();
            check("bp_data", out_data, APPB_OUT);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_drop", {127'd0, out_valid}, 128'd0);
        check("bp_ready_back", {127'd0, in_ready}, 128'd1);
        check("bp_captures", 128'(acc_q.size()), 128'd1);
        $display("txn backpressure out=%h captures=%0d", APPB_OUT, acc_q.size());

        // Asynchronous reset while the third column is being mixed.
        in_data = rand128(); in_bypass = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", {127'd0, out_valid}, 128'd0);
        check("arst_out_data", out_data, 128'd0);
        check("arst_in_ready", {127'd0, in_ready}, 128'd1);
        check("arst_busy", {127'd0, busy}, 128'd0);
        tick();
        rst = 1'b0;
        tick();
        do_txn("post_rst", APPB_IN, 1'b0, 0, res, lat);
        check("post_rst_data", res, APPB_OUT);
        $display("txn post_rst out=%h lat=%0d", res, lat);

        // Random transactions, random bypass and output stalls.
        for (int t = 0; t < 8; t++) begin
            logic byp;
            int hold;
            d = rand128();
            byp = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(0, 3);
            do_txn("rand", d, byp, hold, res, lat);
            check("rand_data", res, mix_ref(d, byp));
            check("rand_lat", 128'(lat), 128'((byp ? 1 : 5) + hold));
            $display("txn rand    in=%h byp=%0d out=%h lat=%0d", d, byp, res, lat);
        end

        // Back-to-back with both handshakes held high.
        acc_q.delete(); exp_q.delete(); got_q.delete();
        out_ready = 1'b1; in_bypass = 1'b0;
        in_data = rand128(); in_valid = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 100) begin
            tick(); n++;
            if (acc_q.size() == 3) in_valid = 1'b0;
            else in_data = (busy ? in_data : rand128());
        end
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 3 && n < 100) begin tick(); n++; end
        check("b2b_count", 128'(got_q.size()), 128'd3);
        for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
            check("b2b_data", got_q[i], exp_q[i]);
            $display("txn b2b%0d    out=%h exp=%h", i, got_q[i], exp_q[i]);
        end
        if (acc_q.size() == 3) begin
            check("b2b_space01", 128'(acc_q[1] - acc_q[0]), 128'd6);
            check("b2b_space12", 128'(acc_q[2] - acc_q[1]), 128'd6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
